fifo_flagged: RTL
=================

FIFO_FLAGGED -- requirements
Module: fifo_flagged

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of entries, power of two, >= 2.
REQ-002 SHALL have parameter WIDTH, default 2: data bits per entry, >= 1.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-1: almost_full threshold (1..DEPTH).
REQ-004 SHALL have parameter AE_LEVEL, default 1: almost_empty threshold (0..DEPTH-1).
REQ-005 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port reset  in  1  one clock; reset is synchronous and active-low.
REQ-007 SHALL have port in  in  WIDTH  write data.
REQ-008 SHALL have port push  in  1  write request.
REQ-009 SHALL have port pop  in  1  read request.
REQ-010 SHALL have port clr_err  in  1  clears sticky error flags.
REQ-011 SHALL have port out  out  WIDTH  head entry (show-ahead).
REQ-012 SHALL have port full  out  1  count == DEPTH.
REQ-013 SHALL have port empty  out  1  count == 0.
REQ-014 SHALL have port almost_full  out  1  count >= AF_LEVEL.
REQ-015 SHALL have port almost_empty  out  1  count <= AE_LEVEL.
REQ-016 SHALL have port count  out  clog2(DEPTH+1)  current occupancy.
REQ-017 SHALL have port overflow  out  1  sticky: push rejected while full.
REQ-018 SHALL have port underflow  out  1  sticky: pop requested while empty.

Function
REQ-019 SHALL accept push when !full, or when full and pop asserted same cycle; entry written at tail, visible next cycle.
REQ-020 SHALL accept pop when !empty; head advances next cycle.
REQ-021 SHALL, on push and pop both accepted, leave count unchanged and advance both pointers.
REQ-022 SHALL, on push&pop while empty, perform push only, set underflow, count becomes 1.
REQ-023 SHALL, on push while full without pop, drop data, leave state unchanged, set overflow.
REQ-024 SHALL, on pop while empty without push, leave state unchanged, set underflow.
REQ-025 SHALL drive out combinationally from head entry when !empty and all-zero when empty.
REQ-026 SHALL derive full, empty, almost_full, almost_empty combinationally from registered count (zero-cycle latency from count).
REQ-027 SHALL wrap read/write pointers modulo DEPTH with no bubble.
REQ-028 SHALL hold overflow/underflow until clr_err=1; clr_err has priority over a same-cycle set.
REQ-029 SHALL keep count in 0..DEPTH at all times; no arithmetic wrap of count.

Reset
REQ-030 SHALL, when reset=0 at a rising edge, set pointers=0, count=0, overflow=0, underflow=0; push/pop ignored that cycle.
REQ-031 SHALL yield after reset: out=0, empty=1, full=0, almost_empty=1, almost_full=0 (AF_LEVEL>0).
REQ-032 SHALL discard all contents on reset mid-operation; storage array need not be cleared.

Structure
REQ-033 SHALL place pointer-width and count-width helper constants (clog2-based) in shared package fifo_pkg.
REQ-034 SHALL implement storage as sub-module fifo_mem (DEPTH x WIDTH, one sync write port, one async read port).
REQ-035 SHALL keep pointer, count and flag logic in fifo_flagged itself.

Verification (DEPTH=4, WIDTH=2, AF_LEVEL=3, AE_LEVEL=1)
REQ-036 SHALL check: reset then push 11,01,10 -> out=11, count=3, almost_full=1, full=0, empty=0.
REQ-037 SHALL check: from there push 01 with pop -> out=01, count=3; push 11 -> full=1, count=4.
REQ-038 SHALL check: full, push 10 without pop -> contents unchanged, out unchanged, overflow=1; clr_err -> overflow=0.
REQ-039 SHALL check: full, push 01 with pop -> count=4, head advances, new tail 01 read out after 3 further pops.
REQ-040 SHALL check: empty, pop -> underflow=1, out=00; empty, push 10 with pop -> count=1, out=10.
REQ-041 SHALL check: reset=0 asserted with count=3 and push=1 -> next cycle count=0, empty=1, out=00.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the flagged FIFO and its storage.
package fifo_pkg;

  // A depth of 1 would give a zero-width pointer, so the width is clamped to 1.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x WIDTH, one synchronous write port, one asynchronous read port.
module fifo_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;

  // Contents are never reset; occupancy lives entirely in the pointers and count.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_flagged.sv
// Show-ahead FIFO with occupancy flags and sticky overflow/underflow errors.
module fifo_flagged
  import fifo_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int WIDTH    = 2,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         in,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clr_err,
  output logic [WIDTH-1:0]         out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [cnt_w(DEPTH)-1:0]  count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [AW-1:0]    wptr, rptr;
  logic [WIDTH-1:0] rdata;
  logic             push_ok, pop_ok;

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_LEVEL));
  assign almost_empty = (count <= CW'(AE_LEVEL));

  // A full FIFO still takes a push when a pop frees the head slot in the same cycle.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  fifo_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (push_ok && reset),
    .waddr (wptr),
    .wdata (in),
    .raddr (rptr),
    .rdata (rdata)
  );

  assign out = empty ? '0 : rdata;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (clr_err) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (push && full && !pop) overflow  <= 1'b1;
        if (pop && empty)         underflow <= 1'b1;
      end
    end
  end

endmodule
